// File: rtl/vsi_issue_pkg.sv
// Shared types for the VSI op issuer.
// Entry packing and the issuer FSM states.
package vsi_issue_pkg;

  localparam int VSI_OP_W = 32;
  localparam int ENTRY_W  = 34;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SETTLE,
    WAIT_IDLE
  } issuer_state_e;

  typedef struct packed {
    logic                sew;
    logic                lmul;
    logic [VSI_OP_W-1:0] op;
  } vsi_entry_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [VSI_OP_W-1:0] op,
    input logic                lmul,
    input logic                sew
  );
    return {sew, lmul, op};
  endfunction

  function automatic vsi_entry_t unpack_entry(
    input logic [ENTRY_W-1:0] e
  );
    return vsi_entry_t'(e);
  endfunction

endpackage

// File: rtl/vsi_op_fifo.sv
// Op queue: registered storage, no fall-through.
// Occupancy kept in its own counter; pointers wrap freely.
module vsi_op_fifo
  import vsi_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (pop_ok) rp <= rp + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vsi_op_issuer.sv
// VSI op channel initiator: queues host ops, issues them
// to the coprocessor, and implements the drain/idle fence.
module vsi_op_issuer
  import vsi_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    vsi_clk,
  input  logic                    vsi_rst,
  input  logic [VSI_OP_W-1:0]     host_op,
  input  logic                    host_lmul,
  input  logic                    host_sew,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic                    fence_req,
  output logic                    fence_done,
  output logic [VSI_OP_W-1:0]     vsi_op,
  output logic                    vsi_lmul,
  output logic                    vsi_sew,
  output logic                    vsi_op_valid,
  input  logic                    vsi_op_ready,
  input  logic                    vsi_cop_idle,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic [CNT_W-1:0]        issued_cnt
);

  issuer_state_e state;
  issuer_state_e state_nx;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  vsi_entry_t         head_e;

  assign host_ready   = (state == RUN) && !full;
  assign push         = host_valid && host_ready;
  assign vsi_op_valid = !empty;
  assign pop          = vsi_op_valid && vsi_op_ready;

  assign head_e   = unpack_entry(head);
  assign vsi_op   = head_e.op;
  assign vsi_lmul = head_e.lmul;
  assign vsi_sew  = head_e.sew;

  vsi_op_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (vsi_clk),
    .rst   (vsi_rst),
    .push  (push),
    .pop   (pop),
    .wdata (pack_entry(host_op, host_lmul, host_sew)),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  always_ff @(posedge vsi_clk or posedge vsi_rst) begin
    if (vsi_rst) begin
      state      <= RUN;
      issued_cnt <= '0;
    end else begin
      state <= state_nx;
      if (pop) issued_cnt <= issued_cnt + 1'b1;
    end
  end

  // Idle is only meaningful once the last op has had a cycle to land.
  always_comb begin
    state_nx   = state;
    fence_done = 1'b0;
    unique case (state)
      RUN:       if (fence_req) state_nx = DRAIN;
      DRAIN:     if (empty) state_nx = SETTLE;
      SETTLE:    state_nx = WAIT_IDLE;
      WAIT_IDLE: begin
        if (vsi_cop_idle) begin
          fence_done = 1'b1;
          state_nx   = RUN;
        end
      end
      default:   state_nx = RUN;
    endcase
  end

endmodule

// File: tb/tb_vsi_op_issuer.sv
// Self-checking bench for vsi_op_issuer: random ops
// against a queue-based model of the op channel.
module tb_vsi_op_issuer;
  import vsi_issue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic                vsi_clk;
  logic                vsi_rst;
  logic [31:0]         host_op;
  logic                host_lmul;
  logic                host_sew;
  logic                host_valid;
  logic                host_ready;
  logic                fence_req;
  logic                fence_done;
  logic [31:0]         vsi_op;
  logic                vsi_lmul;
  logic                vsi_sew;
  logic                vsi_op_valid;
  logic                vsi_op_ready;
  logic                vsi_cop_idle;
  logic [2:0]          q_count;
  logic [CNT_W-1:0]    issued_cnt;

  vsi_op_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .vsi_clk      (vsi_clk),
    .vsi_rst      (vsi_rst),
    .host_op      (host_op),
    .host_lmul    (host_lmul),
    .host_sew     (host_sew),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .fence_req    (fence_req),
    .fence_done   (fence_done),
    .vsi_op       (vsi_op),
    .vsi_lmul     (vsi_lmul),
    .vsi_sew      (vsi_sew),
    .vsi_op_valid (vsi_op_valid),
    .vsi_op_ready (vsi_op_ready),
    .vsi_cop_idle (vsi_cop_idle),
    .q_count      (q_count),
    .issued_cnt   (issued_cnt)
  );

  initial vsi_clk = 1'b0;
  always #5 vsi_clk = ~vsi_clk;

  // Model: op queue, handshake count, fence phase
  // (0 open, 1 draining, 2 settling, 3 awaiting idle).
  logic [33:0]      mq[$];
  logic [CNT_W-1:0] m_issued;
  int               fph;
  int               n_assert;
  int               n_fail;
  int               done_seen;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_op();
    host_op   = $urandom;
    host_lmul = 1'($urandom_range(0, 1));
    host_sew  = 1'($urandom_range(0, 1));
  endtask

  task automatic model_clear();
    mq.delete();
    m_issued = '0;
    fph      = 0;
  endtask

  // Check outputs mid-cycle, then advance model and DUT one edge.
  task automatic cycle();
    int  sz;
    bit  mpop;
    bit  mpush;
    @(negedge vsi_clk);
    sz = mq.size();
    chk("host_ready", host_ready, (fph == 0 && sz < DEPTH));
    chk("valid", vsi_op_valid, (sz != 0));
    chk("q_count", q_count, sz);
    chk("issued_cnt", issued_cnt, m_issued);
    chk("fence_done", fence_done, (fph == 3 && vsi_cop_idle));
    if (sz != 0) chk("payload", {vsi_sew, vsi_lmul, vsi_op}, mq[0]);
    if (fence_done === 1'b1) done_seen++;
    mpop  = (sz != 0) && vsi_op_ready;
    mpush = host_valid && (fph == 0) && (sz < DEPTH);
    case (fph)
      0: if (fence_req) fph = 1;
      1: if (sz == 0) fph = 2;
      2: fph = 3;
      default: if (vsi_cop_idle) fph = 0;
    endcase
    if (mpop) begin
      void'(mq.pop_front());
      m_issued = m_issued + 1'b1;
    end
    if (mpush) mq.push_back({host_sew, host_lmul, host_op});
    @(posedge vsi_clk);
    #1;
  endtask

  task automatic do_reset();
    vsi_rst = 1'b1;
    #1;
    chk("rst_valid", vsi_op_valid, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_fence_done", fence_done, 0);
    model_clear();
    @(posedge vsi_clk);
    #1;
    vsi_rst = 1'b0;
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    done_seen    = 0;
    vsi_rst      = 1'b1;
    host_op      = '0;
    host_lmul    = 1'b0;
    host_sew     = 1'b0;
    host_valid   = 1'b0;
    fence_req    = 1'b0;
    vsi_op_ready = 1'b0;
    vsi_cop_idle = 1'b0;
    model_clear();
    #2;
    chk("rst_op", {vsi_sew, vsi_lmul, vsi_op}, 0);
    do_reset();

    // 1: single op, issued next cycle
    host_op      = 32'h0000_0057;
    host_lmul    = 1'b1;
    host_sew     = 1'b0;
    host_valid   = 1'b1;
    vsi_op_ready = 1'b1;
    cycle();
    host_valid = 1'b0;
    chk("t1_valid", vsi_op_valid, 1);
    chk("t1_op", {vsi_sew, vsi_lmul, vsi_op}, 34'h1_0000_0057);
    cycle();
    chk("t1_issued", issued_cnt, 1);

    // 2: backpressure with two queued ops
    vsi_op_ready = 1'b0;
    host_valid   = 1'b1;
    repeat (2) begin
      rand_op();
      cycle();
    end
    host_valid = 1'b0;
    repeat (10) cycle();
    vsi_op_ready = 1'b1;
    repeat (3) cycle();

    // 3: fill past capacity, then push+pop while full
    vsi_op_ready = 1'b0;
    host_valid   = 1'b1;
    repeat (5) begin
      rand_op();
      cycle();
    end
    chk("t3_full_count", q_count, 4);
    chk("t3_full_ready", host_ready, 0);
    rand_op();
    vsi_op_ready = 1'b1;
    cycle();
    chk("t3_push_rejected", q_count, 3);
    host_valid = 1'b0;
    repeat (4) cycle();

    // 4: fence with three queued ops and a busy coprocessor
    vsi_op_ready = 1'b0;
    vsi_cop_idle = 1'b0;
    host_valid   = 1'b1;
    repeat (3) begin
      rand_op();
      cycle();
    end
    done_seen = 0;
    fence_req = 1'b1;
    rand_op();
    cycle();
    fence_req = 1'b0;
    chk("t4_drain_blocks", host_ready, 0);
    vsi_op_ready = 1'b1;
    repeat (3) begin
      rand_op();
      cycle();
    end
    repeat (5) cycle();
    vsi_cop_idle = 1'b1;
    host_valid   = 1'b0;
    repeat (4) cycle();
    chk("t4_done_once", done_seen, 1);

    // 4b: fence on an empty queue with an idle coprocessor
    done_seen = 0;
    fence_req = 1'b1;
    cycle();
    fence_req = 1'b0;
    repeat (2) cycle();
    chk("t4b_early", done_seen, 0);
    cycle();
    chk("t4b_done_4th", done_seen, 1);
    repeat (2) cycle();
    chk("t4b_single", done_seen, 1);

    // 5: reset while ops are queued and valid is high
    vsi_op_ready = 1'b0;
    vsi_cop_idle = 1'b0;
    host_valid   = 1'b1;
    repeat (3) begin
      rand_op();
      cycle();
    end
    host_valid = 1'b0;
    do_reset();
    host_valid   = 1'b1;
    vsi_op_ready = 1'b1;
    rand_op();
    cycle();
    host_valid = 1'b0;
    cycle();
    chk("t5_issued", issued_cnt, 1);

    // 6: counter wrap and pointer wrap at full throughput
    do_reset();
    host_valid   = 1'b1;
    vsi_op_ready = 1'b1;
    repeat (65540) begin
      rand_op();
      cycle();
    end
    host_valid = 1'b0;
    cycle();
    chk("t6_wrap", issued_cnt, 16'h0004);
    chk("t6_empty", q_count, 0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
